// File: rtl/falling_edge_pulse_driver.sv
// Active-low event line driver: one clean LOW_CYCLES pulse per request, then a
// guaranteed RECOVER_CYCLES high time. Optional readback: FALLING_EDGE_DRIVER_READBACK_EN.
`timescale 1ns/1ps

module falling_edge_pulse_driver #(
   parameter int LOW_CYCLES       = 4,
   parameter int RECOVER_CYCLES   = 130,
   parameter int DROP_COUNT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic                        trigger,
   input  logic                        clearStatus,
   input  logic                        lineIn,
   output logic                        outputActiveLow,
   output logic                        busy,
   output logic                        pending,
   output logic [DROP_COUNT_WIDTH-1:0] dropCount,
   output logic                        contention
);

   localparam int MAX_CYCLES = (LOW_CYCLES > RECOVER_CYCLES) ? LOW_CYCLES : RECOVER_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RECOVER = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        pending_q, pending_d;
   logic                        line_q, line_d;
   logic                        busy_q, busy_d;
   logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;
   logic                        drop_event;
   logic                        last_recover;

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pending_d    = pending_q;
      drop_event   = 1'b0;
      last_recover = (state_q == ST_RECOVER) && (cnt_q == '0);

      unique case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_ASSERT;
               cnt_d   = LOW_LOAD;
            end
         end
         ST_ASSERT: begin
            if (cnt_q == '0) begin
               state_d = ST_RECOVER;
               cnt_d   = REC_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) begin
               if (pending_q || trigger) begin
                  state_d = ST_ASSERT;
                  cnt_d   = LOW_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // On the last recovery cycle a queued request is consumed; a coincident
      // trigger re-queues only if something was already waiting.
      if (last_recover) begin
         pending_d = pending_q & trigger;
      end else if ((state_q != ST_IDLE) && trigger) begin
         if (pending_q) begin
            drop_event = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (state_d == ST_IDLE) begin
         pending_d = 1'b0;
      end

      line_d = (state_d != ST_ASSERT);
      busy_d = (state_d != ST_IDLE);

      if (clearStatus) begin
         drop_d = drop_event ? DROP_COUNT_WIDTH'(1) : '0;
      end else if (drop_event && (drop_q != '1)) begin
         drop_d = drop_q + DROP_COUNT_WIDTH'(1);
      end else begin
         drop_d = drop_q;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         line_q    <= 1'b1;
         busy_q    <= 1'b0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         line_q    <= line_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
      end
   end

   assign outputActiveLow = line_q;
   assign busy            = busy_q;
   assign pending         = pending_q;
   assign dropCount       = drop_q;

`ifdef FALLING_EDGE_DRIVER_READBACK_EN
   logic [1:0] sync_q, sync_d;
   logic       contention_q, contention_d;

   always_comb begin
      sync_d       = {sync_q[0], lineIn};
      contention_d = (clearStatus ? 1'b0 : contention_q)
                   | ((state_q == ST_IDLE) && !sync_q[1]);
   end

   // NOTE: synchronizer resets to the idle-high line level so release never flags contention.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync_q       <= 2'b11;
         contention_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         contention_q <= contention_d;
      end
   end

   assign contention = contention_q;
`else
   logic unused_line_in;
   assign unused_line_in = lineIn;
   assign contention     = 1'b0;
`endif

endmodule
